noc_local_ni: RTL and testbench

NOC_LOCAL_NI -- requirements
Module: noc_local_ni

---
 rtl/noc_pkg.sv | 25 ++
 rtl/noc_local_ni_if.sv | 32 +++
 rtl/noc_ni_fifo.sv | 35 +++
 rtl/noc_local_ni.sv | 52 +++++
 tb/tb_noc_local_ni.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit geometry, field positions and default NI sizing shared by the NI blocks
package noc_pkg;
  localparam int FLIT_W = 16;
  localparam int COORD_W = 4;
  localparam int PAY_W = 8;
  localparam int PAY_LO = 8;
  localparam int X_LO = 4;
  localparam int Y_LO = 0;
  localparam int DEF_CREDITS = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic logic [FLIT_W-1:0] make_flit(logic [PAY_W-1:0] p, logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[PAY_LO+:PAY_W] = p;
    f[X_LO+:COORD_W] = x;
    f[Y_LO+:COORD_W] = y;
    return f;
  endfunction
  function automatic logic [COORD_W-1:0] dest_x(logic [FLIT_W-1:0] f);
    return f[X_LO+:COORD_W];
  endfunction
  function automatic logic [COORD_W-1:0] dest_y(logic [FLIT_W-1:0] f);
    return f[Y_LO+:COORD_W];
  endfunction
endpackage

// File: rtl/noc_local_ni_if.sv
// noc_local_ni_if: core-side and router-side signals of the local network interface
interface noc_local_ni_if;
  import noc_pkg::*;
  logic [PAY_W-1:0] core_tx_payload;
  logic [COORD_W-1:0] core_tx_dest_x;
  logic [COORD_W-1:0] core_tx_dest_y;
  logic core_tx_valid;
  logic core_tx_ready;
  logic [FLIT_W-1:0] net_tx_data;
  logic net_tx_enable;
  logic net_tx_credit_i;
  logic [FLIT_W-1:0] net_rx_data;
  logic net_rx_enable;
  logic net_rx_credit_o;
  logic [FLIT_W-1:0] core_rx_data;
  logic core_rx_valid;
  logic core_rx_ready;
  logic misroute_err;
  logic overflow_err;
  modport master (
    output core_tx_payload, core_tx_dest_x, core_tx_dest_y, core_tx_valid, net_tx_credit_i,
    output net_rx_data, net_rx_enable, core_rx_ready,
    input core_tx_ready, net_tx_data, net_tx_enable, net_rx_credit_o, core_rx_data, core_rx_valid,
    input misroute_err, overflow_err
  );
  modport slave (
    input core_tx_payload, core_tx_dest_x, core_tx_dest_y, core_tx_valid, net_tx_credit_i,
    input net_rx_data, net_rx_enable, core_rx_ready,
    output core_tx_ready, net_tx_data, net_tx_enable, net_rx_credit_o, core_rx_data, core_rx_valid,
    output misroute_err, overflow_err
  );
endinterface

// File: rtl/noc_ni_fifo.sv
// noc_ni_fifo: synchronous FIFO; a push while full is accepted only when a pop frees the slot
module noc_ni_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/noc_local_ni.sv
// noc_local_ni: core-to-router local port with credit-based TX flow control and a credit-returning RX buffer
module noc_local_ni import noc_pkg::*; #(
  parameter logic [COORD_W-1:0] XCOORD = 4'b0000,
  parameter logic [COORD_W-1:0] YCOORD = 4'b0000,
  parameter int CREDITS = DEF_CREDITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic clk,
  input logic rst,
  noc_local_ni_if.slave ni
);
  localparam int CW = $clog2(CREDITS + 1);
  logic [CW-1:0] credits;
  logic [FLIT_W-1:0] tx_head, rx_head;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, send, rx_pop, bad_dest;
  assign ni.core_tx_ready = !tx_full;
  assign tx_push = ni.core_tx_valid && !tx_full;
  assign send = !tx_empty && credits != '0;
  assign ni.core_rx_valid = !rx_empty;
  assign ni.core_rx_data = rx_head;
  assign rx_pop = !rx_empty && ni.core_rx_ready;
  assign bad_dest = dest_x(ni.net_rx_data) != XCOORD || dest_y(ni.net_rx_data) != YCOORD;
  noc_ni_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(send),
    .din(make_flit(ni.core_tx_payload, ni.core_tx_dest_x, ni.core_tx_dest_y)),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );
  noc_ni_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(ni.net_rx_enable), .pop(rx_pop),
    .din(ni.net_rx_data), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  // counter moves with the send decision so a zero count blocks the very next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(CREDITS);
      ni.net_tx_enable <= 1'b0;
      ni.net_tx_data <= '0;
      ni.net_rx_credit_o <= 1'b0;
      ni.misroute_err <= 1'b0;
      ni.overflow_err <= 1'b0;
    end else begin
      ni.net_tx_enable <= send;
      ni.net_tx_data <= send ? tx_head : ni.net_tx_data;
      credits <= (send && !ni.net_tx_credit_i) ? credits - 1'b1 :
                 (!send && ni.net_tx_credit_i && credits != CW'(CREDITS)) ? credits + 1'b1 : credits;
      ni.net_rx_credit_o <= rx_pop;
      ni.misroute_err <= ni.misroute_err || (ni.net_rx_enable && bad_dest);
      ni.overflow_err <= ni.overflow_err || (ni.net_rx_enable && rx_full && !rx_pop);
    end
  end
endmodule

// File: tb/tb_noc_local_ni.sv
// tb_noc_local_ni: directed and random stimulus checked against a queue-based NI model
module tb_noc_local_ni;
  logic clk, rst;
  noc_local_ni_if ifc();
  noc_local_ni #(.XCOORD(4'd1), .YCOORD(4'd2), .CREDITS(4), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .ni(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, sends = 0, rxcr = 0, first_send = -1, cred = 4;
  logic [15:0] txq[$], rxq[$], sdata[$];
  int scyc[$];
  logic m_en = 0, m_cr = 0, m_mis = 0, m_ovf = 0;
  logic [15:0] m_data = '0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit acc, snd, pop, drop;
    @(posedge clk);
    cyc++;
    if (rst) begin
      txq.delete(); rxq.delete();
      cred = 4; m_en = 0; m_data = '0; m_cr = 0; m_mis = 0; m_ovf = 0;
    end else begin
      acc = ifc.core_tx_valid && txq.size() < 4;
      snd = txq.size() > 0 && cred > 0;
      m_en = snd;
      if (snd) m_data = txq.pop_front();
      cred = cred - int'(snd) + int'(ifc.net_tx_credit_i);
      if (cred > 4) cred = 4;
      if (acc) txq.push_back({ifc.core_tx_payload, ifc.core_tx_dest_x, ifc.core_tx_dest_y});
      pop = rxq.size() > 0 && ifc.core_rx_ready;
      drop = ifc.net_rx_enable && rxq.size() == 4 && !pop;
      m_cr = pop;
      if (pop) void'(rxq.pop_front());
      if (ifc.net_rx_enable) begin
        if (!drop) rxq.push_back(ifc.net_rx_data);
        if (ifc.net_rx_data[7:4] != 4'd1 || ifc.net_rx_data[3:0] != 4'd2) m_mis = 1;
      end
      if (drop) m_ovf = 1;
    end
    @(negedge clk);
    chk("tx_ready", 32'(ifc.core_tx_ready), 32'(txq.size() < 4));
    chk("rx_valid", 32'(ifc.core_rx_valid), 32'(rxq.size() > 0));
    if (rxq.size() > 0) chk("rx_data", 32'(ifc.core_rx_data), 32'(rxq[0]));
    chk("tx_en", 32'(ifc.net_tx_enable), 32'(m_en));
    chk("tx_data", 32'(ifc.net_tx_data), 32'(m_data));
    chk("rx_credit", 32'(ifc.net_rx_credit_o), 32'(m_cr));
    chk("misroute", 32'(ifc.misroute_err), 32'(m_mis));
    chk("overflow", 32'(ifc.overflow_err), 32'(m_ovf));
    chk("credits", 32'(dut.credits), 32'(cred));
    if (ifc.net_tx_enable) begin
      sends++;
      if (first_send < 0) first_send = cyc;
      sdata.push_back(ifc.net_tx_data);
      scyc.push_back(cyc);
    end
    if (ifc.net_rx_credit_o) rxcr++;
  endtask
  task automatic set_tx(bit v, logic [7:0] p, logic [3:0] x, logic [3:0] y);
    ifc.core_tx_valid = v; ifc.core_tx_payload = p; ifc.core_tx_dest_x = x; ifc.core_tx_dest_y = y;
  endtask
  task automatic set_rx(bit e, logic [15:0] d);
    ifc.net_rx_enable = e; ifc.net_rx_data = d;
  endtask
  initial begin
    int ca, cc, n, guard;
    rst = 1;
    set_tx(0, 0, 0, 0); set_rx(0, 0);
    ifc.net_tx_credit_i = 0; ifc.core_rx_ready = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    chk("rst_cred", 32'(dut.credits), 32'd4);
    chk("rst_ready", 32'(ifc.core_tx_ready), 32'd1);
    // three flits to 0/0
    sends = 0; first_send = -1; sdata.delete(); scyc.delete();
    set_tx(1, 8'hA1, 0, 0); tick(); ca = cyc;
    set_tx(1, 8'hA2, 0, 0); tick();
    set_tx(1, 8'hA3, 0, 0); tick();
    set_tx(0, 0, 0, 0);
    repeat (4) tick();
    chk("lat_first", 32'(first_send), 32'(ca + 1));
    chk("three_sends", 32'(sends), 32'd3);
    if (sends == 3) begin
      chk("d0", 32'(sdata[0]), 32'h0000A100);
      chk("d1", 32'(sdata[1]), 32'h0000A200);
      chk("d2", 32'(sdata[2]), 32'h0000A300);
      chk("back2back", 32'(scyc[2] - scyc[0]), 32'd2);
    end
    chk("cred_after3", 32'(dut.credits), 32'd1);
    ifc.net_tx_credit_i = 1; repeat (3) tick(); ifc.net_tx_credit_i = 0;
    chk("cred_restored", 32'(dut.credits), 32'd4);
    // six flits, four credits
    sends = 0; n = 0; guard = 0;
    while (n < 6 && guard < 20) begin
      set_tx(1, 8'hB0 + 8'(n), 4'(n), 4'(n));
      guard++;
      if (ifc.core_tx_ready) n++;
      tick();
    end
    set_tx(0, 0, 0, 0);
    repeat (5) tick();
    chk("six_accepted", 32'(n), 32'd6);
    chk("four_sent", 32'(sends), 32'd4);
    chk("cred_zero", 32'(dut.credits), 32'd0);
    ifc.net_tx_credit_i = 1; tick(); cc = cyc; ifc.net_tx_credit_i = 0;
    repeat (3) tick();
    chk("one_more", 32'(sends), 32'd5);
    chk("one_more_cyc", 32'(scyc[$]), 32'(cc + 1));
    ifc.net_tx_credit_i = 1; repeat (6) tick(); ifc.net_tx_credit_i = 0;
    repeat (2) tick();
    chk("drained", 32'(sends), 32'd6);
    chk("cred_sat", 32'(dut.credits), 32'd4);
    // bring counter to 1, then overlap send and credit
    for (int i = 0; i < 3; i++) begin set_tx(1, 8'hC0 + 8'(i), 0, 0); tick(); end
    set_tx(0, 0, 0, 0); repeat (3) tick();
    chk("cred_one", 32'(dut.credits), 32'd1);
    sends = 0; scyc.delete();
    set_tx(1, 8'hC8, 0, 0); tick();
    ifc.net_tx_credit_i = 1;
    set_tx(1, 8'hC9, 0, 0); tick();
    set_tx(1, 8'hCA, 0, 0); tick();
    set_tx(0, 0, 0, 0); tick();
    ifc.net_tx_credit_i = 0; repeat (2) tick();
    chk("overlap_sends", 32'(sends), 32'd3);
    if (sends == 3) chk("overlap_nogap", 32'(scyc[2] - scyc[0]), 32'd2);
    chk("overlap_cred", 32'(dut.credits), 32'd1);
    ifc.net_tx_credit_i = 1; repeat (3) tick(); ifc.net_tx_credit_i = 0;
    // RX fill, overflow, drain
    rxcr = 0;
    for (int i = 0; i < 4; i++) begin set_rx(1, {8'hD0 + 8'(i), 8'h12}); tick(); end
    set_rx(1, 16'hEE12); tick();
    set_rx(0, 0); tick();
    chk("ovf_set", 32'(ifc.overflow_err), 32'd1);
    chk("rx_head_kept", 32'(ifc.core_rx_data), 32'h0000D012);
    ifc.core_rx_ready = 1; repeat (4) tick(); ifc.core_rx_ready = 0;
    repeat (2) tick();
    chk("rx_credits", 32'(rxcr), 32'd4);
    chk("rx_empty", 32'(ifc.core_rx_valid), 32'd0);
    // destination checking
    set_rx(1, 16'h0012); tick(); set_rx(0, 0); tick();
    chk("mis_clear", 32'(ifc.misroute_err), 32'd0);
    set_rx(1, 16'h0013); tick(); set_rx(0, 0);
    ifc.core_rx_ready = 1; tick();
    chk("mis_set", 32'(ifc.misroute_err), 32'd1);
    chk("mis_delivered", 32'(ifc.core_rx_data), 32'h00000013);
    tick(); ifc.core_rx_ready = 0; tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_tx($urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom), 4'($urandom));
      ifc.net_tx_credit_i = $urandom_range(0, 3) == 0;
      set_rx($urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1 ? {8'($urandom), 8'h12} : 16'($urandom));
      ifc.core_rx_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    // reset with buffered data
    set_tx(0, 0, 0, 0); set_rx(0, 0); ifc.net_tx_credit_i = 0; ifc.core_rx_ready = 0;
    for (int i = 0; i < 3; i++) begin set_tx(1, 8'hF0 + 8'(i), 1, 1); set_rx(1, {8'hF0 + 8'(i), 8'h12}); tick(); end
    chk("pre_rst_rx", 32'(ifc.core_rx_valid), 32'd1);
    set_tx(1, 8'hFF, 1, 1); set_rx(1, 16'hFF12); ifc.core_rx_ready = 1; ifc.net_tx_credit_i = 1;
    rst = 1; tick(); rst = 0;
    set_tx(0, 0, 0, 0); set_rx(0, 0); ifc.core_rx_ready = 0; ifc.net_tx_credit_i = 0;
    chk("rst_en", 32'(ifc.net_tx_enable), 32'd0);
    chk("rst_data", 32'(ifc.net_tx_data), 32'd0);
    chk("rst_rxcr", 32'(ifc.net_rx_credit_o), 32'd0);
    chk("rst_rxv", 32'(ifc.core_rx_valid), 32'd0);
    chk("rst_txr", 32'(ifc.core_tx_ready), 32'd1);
    chk("rst_errs", 32'({ifc.misroute_err, ifc.overflow_err}), 32'd0);
    chk("rst_cred2", 32'(dut.credits), 32'd4);
    tick();
    chk("post_rst_en", 32'(ifc.net_tx_enable), 32'd0);
    chk("post_rst_rxcr", 32'(ifc.net_rx_credit_o), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
